// File: rtl/cnn_frame_sched.sv
// Frame sequencer for camera -> CNN -> LCD: gates capture, launches the CNN and
// ping-pongs the two output banks so the LCD only ever scans a finished frame.
module cnn_frame_sched #(
    parameter int unsigned TIMEOUT = 400000,
    parameter int unsigned TO_W    = 20,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEnable,
    input  logic             iSingleShot,
    input  logic             iErrClr,
    input  logic             iCamVsync,
    input  logic             iCamFrameDone,
    input  logic             iCnnDone,
    input  logic             iLcdVsync,
    output logic             oCapEn,
    output logic             oCnnStart,
    output logic             oWrBank,
    output logic             oRdBank,
    output logic             oBusy,
    output logic [CNT_W-1:0] oFrameCnt,
    output logic [CNT_W-1:0] oDropCnt,
    output logic             oTimeoutErr
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitVs,
        StCapture,
        StRun,
        StSwapPend
    } state_e;

    localparam logic [TO_W-1:0] W_TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            r_state;
    logic              r_cap_en;
    logic              r_cnn_start;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic              r_busy;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_timeout_err;
    logic [TO_W-1:0]   r_wdog;

    logic              w_swap;
    logic              w_go_idle;

    // Done+LCD vsync together in RUN publishes without passing through SWAP_PEND.
    assign w_swap = ((r_state == StRun) && iCnnDone && iLcdVsync) ||
                    ((r_state == StSwapPend) && iLcdVsync);
    assign w_go_idle = iSingleShot || !iEnable;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state       <= StIdle;
            r_cap_en      <= 1'b0;
            r_cnn_start   <= 1'b0;
            r_wr_bank     <= 1'b1;
            r_rd_bank     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_cnn_start <= 1'b0;
            if (iErrClr) begin
                r_timeout_err <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (iEnable) begin
                        r_state <= StWaitVs;
                        r_busy  <= 1'b1;
                    end
                end
                StWaitVs: begin
                    if (!iEnable) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else if (iCamVsync) begin
                        r_state  <= StCapture;
                        r_cap_en <= 1'b1;
                    end
                end
                StCapture: begin
                    if (iCamFrameDone) begin
                        r_state     <= StRun;
                        r_cap_en    <= 1'b0;
                        r_cnn_start <= 1'b1;
                        r_wdog      <= '0;
                    end
                end
                StRun: begin
                    if (iCnnDone) begin
                        if (!iLcdVsync) begin
                            r_state <= StSwapPend;
                        end
                    end else if (r_wdog == W_TO_LAST) begin
                        // Abort: keep the published bank, count the lost frame.
                        r_timeout_err <= 1'b1;
                        r_drop_cnt    <= r_drop_cnt + 1'b1;
                        r_state       <= iSingleShot ? StIdle : StWaitVs;
                        r_busy        <= !iSingleShot;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                StSwapPend: begin
                end
                default: begin
                    r_state  <= StIdle;
                    r_busy   <= 1'b0;
                    r_cap_en <= 1'b0;
                end
            endcase

            if (w_swap) begin
                r_rd_bank   <= r_wr_bank;
                r_wr_bank   <= ~r_wr_bank;
                r_frame_cnt <= r_frame_cnt + 1'b1;
                r_state     <= w_go_idle ? StIdle : StWaitVs;
                r_busy      <= !w_go_idle;
            end
        end
    end

    assign oCapEn      = r_cap_en;
    assign oCnnStart   = r_cnn_start;
    assign oWrBank     = r_wr_bank;
    assign oRdBank     = r_rd_bank;
    assign oBusy       = r_busy;
    assign oFrameCnt   = r_frame_cnt;
    assign oDropCnt    = r_drop_cnt;
    assign oTimeoutErr = r_timeout_err;

endmodule

// File: tb/tb_cnn_frame_sched.sv
// Randomised frame-level bench for cnn_frame_sched; expectations come from frame
// and drop tallies kept by the bench, banks derived from the frame-count parity.
module tb_cnn_frame_sched;

    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned TO_W    = 20;
    localparam int unsigned CNT_W   = 16;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic             iEnable = 1'b0;
    logic             iSingleShot = 1'b0;
    logic             iErrClr = 1'b0;
    logic             iCamVsync = 1'b0;
    logic             iCamFrameDone = 1'b0;
    logic             iCnnDone = 1'b0;
    logic             iLcdVsync = 1'b0;
    logic             oCapEn;
    logic             oCnnStart;
    logic             oWrBank;
    logic             oRdBank;
    logic             oBusy;
    logic [CNT_W-1:0] oFrameCnt;
    logic [CNT_W-1:0] oDropCnt;
    logic             oTimeoutErr;

    cnn_frame_sched #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W),
        .CNT_W   (CNT_W)
    ) u_dut (
        .iClk          (iClk),
        .iRst          (iRst),
        .iEnable       (iEnable),
        .iSingleShot   (iSingleShot),
        .iErrClr       (iErrClr),
        .iCamVsync     (iCamVsync),
        .iCamFrameDone (iCamFrameDone),
        .iCnnDone      (iCnnDone),
        .iLcdVsync     (iLcdVsync),
        .oCapEn        (oCapEn),
        .oCnnStart     (oCnnStart),
        .oWrBank       (oWrBank),
        .oRdBank       (oRdBank),
        .oBusy         (oBusy),
        .oFrameCnt     (oFrameCnt),
        .oDropCnt      (oDropCnt),
        .oTimeoutErr   (oTimeoutErr)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;
    int exp_drops  = 0;
    int cap_cycles = 0;
    int start_cnt  = 0;
    bit mon_on     = 1'b0;
    bit prev_start = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample away from the active edge; banks must always differ.
    always @(negedge iClk) begin
        if (mon_on) begin
            cap_cycles += int'(oCapEn);
            start_cnt  += int'(oCnnStart);
            if (oWrBank === oRdBank) check("bank_invariant", {31'd0, oWrBank}, {31'd0, ~oRdBank});
            if (prev_start && oCnnStart) check("start_single_cycle", 32'd1, 32'd0);
            prev_start = oCnnStart;
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // One cycle with random pulses on lines that must be ignored in the current state.
    task automatic noise_tick(input bit fd_ok, input bit lcd_ok, input bit cnn_ok);
        iCamVsync     = ($urandom_range(0, 3) == 0);
        iCamFrameDone = fd_ok  && ($urandom_range(0, 3) == 0);
        iLcdVsync     = lcd_ok && ($urandom_range(0, 3) == 0);
        iCnnDone      = cnn_ok && ($urandom_range(0, 3) == 0);
        tick();
        iCamVsync = 0; iCamFrameDone = 0; iLcdVsync = 0; iCnnDone = 0;
    endtask

    task automatic check_banks(input string tag);
        check({tag, "_rd"}, {31'd0, oRdBank}, exp_frames % 2);
        check({tag, "_wr"}, {31'd0, oWrBank}, 1 - (exp_frames % 2));
        check({tag, "_frames"}, {16'd0, oFrameCnt}, exp_frames % 65536);
    endtask

    // From WAIT_VS: capture cap_len cycles and launch the CNN; returns on the start edge.
    task automatic front(input int cap_len, input bit drop_en);
        int c0;
        int s0;
        c0 = cap_cycles;
        s0 = start_cnt;
        iCamVsync = 1; tick(); iCamVsync = 0;
        check("cap_en_on", {31'd0, oCapEn}, 32'd1);
        if (drop_en) iEnable = 0;
        repeat (cap_len - 1) noise_tick(1'b0, 1'b1, 1'b1);
        iCamFrameDone = 1; tick(); iCamFrameDone = 0;
        check("cap_len", cap_cycles - c0, cap_len);
        check("start_pulse", {31'd0, oCnnStart}, 32'd1);
        check("cap_en_off", {31'd0, oCapEn}, 32'd0);
        check("start_count", start_cnt - s0, 0);
    endtask

    task automatic frame(input int cap_len, input int d, input bit simul, input int vs_dly,
                         input bit drop_en);
        bit go_idle;
        front(cap_len, drop_en);
        tick();
        check("start_drop", {31'd0, oCnnStart}, 32'd0);
        repeat (d - 1) noise_tick(1'b1, 1'b1, 1'b0);
        iCnnDone = 1; iLcdVsync = simul; tick(); iCnnDone = 0; iLcdVsync = 0;
        if (!simul) begin
            check("pend_no_swap", {16'd0, oFrameCnt}, exp_frames % 65536);
            check("pend_busy", {31'd0, oBusy}, 32'd1);
            repeat (vs_dly - 1) noise_tick(1'b1, 1'b0, 1'b1);
            iLcdVsync = 1; tick(); iLcdVsync = 0;
        end
        exp_frames++;
        go_idle = iSingleShot || !iEnable;
        check_banks("swap");
        check("swap_busy", {31'd0, oBusy}, {31'd0, !go_idle});
    endtask

    task automatic timeout_frame(input bit hold_clr);
        logic err_before;
        err_before = oTimeoutErr;
        front($urandom_range(1, 20), 1'b0);
        tick();
        repeat (TIMEOUT - 3) noise_tick(1'b1, 1'b1, 1'b0);
        tick();
        check("to_not_yet_err", {31'd0, oTimeoutErr}, {31'd0, err_before});
        check("to_not_yet_drop", {16'd0, oDropCnt}, exp_drops);
        iErrClr = hold_clr; tick(); iErrClr = 0;
        exp_drops++;
        check("to_err", {31'd0, oTimeoutErr}, 32'd1);
        check("to_drop", {16'd0, oDropCnt}, exp_drops);
        check_banks("to");
        check("to_busy", {31'd0, oBusy}, 32'd1);
        iErrClr = 1; tick(); iErrClr = 0;
        check("err_clr", {31'd0, oTimeoutErr}, 32'd0);
    endtask

    initial begin
        // Reset then idle
        repeat (3) tick();
        check("rst_wr", {31'd0, oWrBank}, 32'd1);
        check("rst_rd", {31'd0, oRdBank}, 32'd0);
        iRst = 0;
        mon_on = 1'b1;
        tick();
        check("idle_busy", {31'd0, oBusy}, 32'd0);
        check_banks("idle");
        check("idle_drop", {16'd0, oDropCnt}, 32'd0);
        check("idle_err", {31'd0, oTimeoutErr}, 32'd0);
        repeat (100) tick();
        check("idle_no_start", start_cnt, 0);
        check("idle_no_cap", cap_cycles, 0);

        // Normal frame, separate done and LCD vsync
        iEnable = 1; tick();
        check("wait_busy", {31'd0, oBusy}, 32'd1);
        frame(50, $urandom_range(30, 99), 1'b0, 30, 1'b0);

        // Three back-to-back simultaneous done/vsync frames
        for (int i = 0; i < 3; i++) frame($urandom_range(1, 40), $urandom_range(1, 99), 1'b1, 1, 1'b0);

        // Random mix
        for (int i = 0; i < 8; i++)
            frame($urandom_range(1, 40), $urandom_range(1, 99), 1'(($urandom_range(0, 1))),
                  $urandom_range(1, 30), 1'b0);
        frame(1, TIMEOUT - 1, 1'b0, 1, 1'b0);

        // Watchdog, then a timeout with a coincident clear (set wins)
        timeout_frame(1'b0);
        timeout_frame(1'b1);

        // Single shot ends in IDLE; then enable dropped mid-capture still completes
        iSingleShot = 1;
        frame($urandom_range(1, 20), $urandom_range(1, 99), 1'b0, $urandom_range(1, 10), 1'b0);
        iSingleShot = 0;
        tick();
        check("after_ss_busy", {31'd0, oBusy}, 32'd1);
        frame($urandom_range(2, 20), $urandom_range(1, 99), 1'b0, $urandom_range(1, 10), 1'b1);
        tick();
        check("disabled_idle", {31'd0, oBusy}, 32'd0);

        // Reset in RUN
        iEnable = 1; tick();
        front(10, 1'b0);
        repeat (10) tick();
        iRst = 1; tick(); iRst = 0; iEnable = 0;
        exp_frames = 0;
        exp_drops  = 0;
        check_banks("rrst");
        check("rrst_busy", {31'd0, oBusy}, 32'd0);
        check("rrst_cap", {31'd0, oCapEn}, 32'd0);
        check("rrst_start", {31'd0, oCnnStart}, 32'd0);
        check("rrst_drop", {16'd0, oDropCnt}, 32'd0);
        tick();
        check("rrst_start_after", {31'd0, oCnnStart}, 32'd0);
        iCnnDone = 1; iLcdVsync = 1; tick(); iCnnDone = 0; iLcdVsync = 0;
        tick();
        check_banks("rrst_late_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sched.md
Name: cnn_frame_sched

Overview:
Frame-level sequencer for the camera → CNN → LCD pipeline. Gates camera capture into the input buffer and launches the CNN on each captured frame. Owns the ping-pong select of the two RGB565 output-buffer banks, so the LCD always scans a complete frame while the CNN writes the other bank. Sits in cnn_top between the AXI-lite control registers and the capture/CNN/LCD blocks.

Parameters:
TIMEOUT, 400000, max cycles allowed from oCnnStart to iCnnDone before the frame is aborted
TO_W, 20, width of the watchdog counter; must satisfy TIMEOUT < 2^TO_W
CNT_W, 16, width of the frame and drop counters

Ports:
iClk  in  1  system clock (100 MHz); all logic on its rising edge
iRst  in  1  synchronous, active-high reset
iEnable  in  1  run enable (iReg0[0]); level
iSingleShot  in  1  1 = process exactly one frame, then return to IDLE (iReg0[1]); level
iErrClr  in  1  single-cycle pulse; clears oTimeoutErr
iCamVsync  in  1  single-cycle pulse at camera frame start (already synchronised to iClk)
iCamFrameDone  in  1  single-cycle pulse when the last pixel is written to the input buffer
iCnnDone  in  1  single-cycle pulse when the last output pixel is written to bank oWrBank
iLcdVsync  in  1  single-cycle pulse at the LCD vertical blanking start
oCapEn  out  1  input-buffer write enable for the capture block
oCnnStart  out  1  single-cycle CNN start pulse
oWrBank  out  1  output-buffer bank the CNN writes
oRdBank  out  1  output-buffer bank the LCD reads
oBusy  out  1  high in every state except IDLE
oFrameCnt  out  CNT_W  frames published to the LCD (wraps)
oDropCnt  out  CNT_W  frames aborted by the watchdog (wraps)
oTimeoutErr  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered. On reset:
  - State = IDLE.
  - oCapEn = 0, oCnnStart = 0, oWrBank = 1, oRdBank = 0, oBusy = 0.
  - oFrameCnt = 0, oDropCnt = 0, oTimeoutErr = 0, watchdog = 0.
- Reset asserted in any state aborts the frame immediately. No pulse is emitted in the reset cycle or the cycle after it.
- States: IDLE, WAIT_VS, CAPTURE, RUN, SWAP_PEND.
- IDLE:
  - iEnable = 1 → WAIT_VS.
- WAIT_VS:
  - iEnable = 0 → IDLE.
  - else iCamVsync → CAPTURE; oCapEn = 1 from the next cycle.
- CAPTURE:
  - oCapEn = 1.
  - iCamVsync is ignored.
  - iCamFrameDone → RUN. In the following cycle oCapEn = 0 and oCnnStart = 1 for exactly one cycle. The watchdog clears to 0 on that same cycle.
- RUN:
  - The watchdog increments every cycle.
  - iCnnDone with iLcdVsync in the same cycle → swap immediately (see swap rules) and go to the post-swap state.
  - iCnnDone alone → SWAP_PEND.
  - Watchdog reaching TIMEOUT−1 without iCnnDone → set oTimeoutErr, increment oDropCnt, no swap, go to WAIT_VS (or IDLE if iSingleShot = 1).
  - iCnnDone and the timeout in the same cycle: iCnnDone wins.
- SWAP_PEND:
  - Waits for iLcdVsync, then swaps.
  - Camera pulses are ignored; the frame in flight is dropped silently (not counted).
- Swap rules, all in one cycle:
  - oRdBank ← oWrBank.
  - oWrBank ← ~oWrBank.
  - oFrameCnt ← oFrameCnt + 1 (wraps to 0).
  - Invariant: oWrBank ≠ oRdBank at all times.
- After the swap:
  - iSingleShot = 1 → IDLE.
  - else iEnable = 1 → WAIT_VS.
  - else → IDLE.
- iEnable deassertion is honoured only in WAIT_VS and after a swap. A frame already started always completes or times out.
- iCamFrameDone outside CAPTURE and iCnnDone outside RUN are ignored.
- oTimeoutErr:
  - Cleared by iErrClr.
  - Set-and-clear in the same cycle: set wins.
- oDropCnt wraps to 0.

Test Plan:
- Reset then idle: iRst high for 3 cycles, iEnable = 0 → oWrBank = 1, oRdBank = 0, oBusy = 0, all counters 0. No oCnnStart for 100 cycles.
- Normal frame: iEnable = 1; iCamVsync; iCamFrameDone 50 cycles later → oCapEn high for exactly those cycles. oCnnStart is a single pulse 1 cycle after iCamFrameDone. iCnnDone at +200, iLcdVsync at +230 → at +231 oRdBank = 1, oWrBank = 0, oFrameCnt = 1.
- Simultaneous done/vsync: iCnnDone and iLcdVsync in the same cycle → swap on the next edge, SWAP_PEND never entered. 3 consecutive frames → oFrameCnt = 3, banks alternate 0/1/0 for oRdBank.
- Watchdog: TIMEOUT = 100, iCnnDone withheld → after 100 cycles in RUN, oTimeoutErr = 1, oDropCnt = 1, banks unchanged, state WAIT_VS. iErrClr pulse → oTimeoutErr = 0.
- Single shot and disable: iSingleShot = 1, one full frame → IDLE with oBusy = 0. Then iSingleShot = 0 and iEnable dropped during CAPTURE → the frame still completes, swaps, then IDLE.
- Reset mid-RUN: assert iRst 10 cycles after oCnnStart → all outputs return to reset values next cycle. A later iCnnDone causes no swap.
